rsa_ctrl: RTL
=============

RSA_CTRL -- requirements
Module: rsa_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/exponent/modulus width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ena  input  1  block enable; gates acceptance of new start only.
REQ-005 SHALL have port start  input  1  level from config register; rising edge requests a run.
REQ-006 SHALL have port irq_en  input  1  enables irq pulse on completion.
REQ-007 SHALL have port plain  input  WIDTH  base operand.
REQ-008 SHALL have port expo  input  WIDTH  exponent.
REQ-009 SHALL have port modulus  input  WIDTH  modulus.
REQ-010 SHALL have port mm_start  output  1  one-cycle request to external modular multiplier.
REQ-011 SHALL have ports mm_a, mm_b, mm_n  output  WIDTH  multiplier operands and modulus.
REQ-012 SHALL have port mm_done  input  1  one-cycle pulse, multiplier result valid.
REQ-013 SHALL have port mm_p  input  WIDTH  (mm_a*mm_b) mod mm_n, valid with mm_done.
REQ-014 SHALL have port rsa_c  output  WIDTH  result plain^expo mod modulus.
REQ-015 SHALL have ports busy, irq, err  output  1 each  run active; completion pulse; zero-modulus flag.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, SQR, SQR_WAIT, MUL, MUL_WAIT, NEXT, DONE.
REQ-017 SHALL detect start rising edge (registered previous level) in IDLE with ena=1 and go to LOAD next cycle; edges while not IDLE or ena=0 are discarded, not queued.
REQ-018 SHALL, on the accepting edge, latch plain, expo, modulus into internal base/exp/mod registers; later input changes have no effect on the run.
REQ-019 SHALL in LOAD set acc=0 if mod==1 else acc=1, bit counter=WIDTH-1, clear err; if mod==0 go to DONE with err=1, else go to SQR.
REQ-020 SHALL in SQR pulse mm_start one cycle with mm_a=mm_b=acc, mm_n=mod, then enter SQR_WAIT.
REQ-021 SHALL in SQR_WAIT hold mm_a/mm_b/mm_n stable, and on mm_done load acc=mm_p and go to MUL if exp[counter]=1 else NEXT.
REQ-022 SHALL in MUL pulse mm_start with mm_a=acc, mm_b=base, mm_n=mod, then MUL_WAIT; on mm_done load acc=mm_p, go to NEXT.
REQ-023 SHALL in NEXT go to DONE when counter==0, else decrement counter and go to SQR.
REQ-024 SHALL issue exactly WIDTH squares plus popcount(expo) multiplies per run (MSB-first square-and-multiply, no leading-zero skip).
REQ-025 SHALL ignore mm_done outside SQR_WAIT/MUL_WAIT; mm_done never coincides with mm_start of the same op.
REQ-026 SHALL in DONE load rsa_c=acc (0 if err), pulse irq one cycle if irq_en=1, return to IDLE next cycle.
REQ-027 SHALL assert busy in every state except IDLE; busy low in the cycle after DONE.
REQ-028 SHALL hold rsa_c and err stable between runs; a new run updates rsa_c only in DONE.
REQ-029 SHALL continue an in-flight run to completion regardless of ena.
REQ-030 SHALL pass base unreduced (plain>=modulus permitted); multiplier contract covers any WIDTH-bit inputs.

Reset
REQ-031 SHALL on rst=1 immediately force IDLE and outputs mm_start=0, mm_a=mm_b=mm_n=0, rsa_c=0, busy=0, irq=0, err=0, counters and latched operands 0, previous-start register 0.
REQ-032 SHALL, if start is high at reset release, treat it as a rising edge in the first enabled IDLE cycle.
REQ-033 SHALL abort a run on reset mid-operation with no irq and rsa_c=0; a late mm_done after reset is ignored.

Verification (WIDTH=8, behavioural multiplier, 3-cycle mm_done latency)
REQ-034 SHALL verify plain=4, expo=13, modulus=23, irq_en=1 -> 11 mm_start pulses, rsa_c=16, one irq pulse, err=0.
REQ-035 SHALL verify expo=0, modulus=23 -> 8 mm_start pulses, rsa_c=1; modulus=1 -> rsa_c=0.
REQ-036 SHALL verify modulus=0 -> zero mm_start pulses, err=1, rsa_c=0, irq pulse, busy for 3 cycles (LOAD, DONE + accept cycle).
REQ-037 SHALL verify start held high across two runs gives one run; a toggle during busy is ignored; edge with ena=0 is ignored.
REQ-038 SHALL verify rst asserted during MUL_WAIT -> outputs reset same cycle, subsequent mm_done ignored, next start runs correctly.
REQ-039 SHALL verify input changes to plain/expo/modulus during a run do not alter rsa_c and that irq_en=0 suppresses irq.

Source files
------------

// File: rtl/rsa_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rsa_ctrl
// Description : MSB-first square-and-multiply sequencer computing
//               plain^expo mod modulus through an external modular multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             irq_en,
    input  logic [WIDTH-1:0] plain,
    input  logic [WIDTH-1:0] expo,
    input  logic [WIDTH-1:0] modulus,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    input  logic             mm_done,
    input  logic [WIDTH-1:0] mm_p,
    output logic [WIDTH-1:0] rsa_c,
    output logic             busy,
    output logic             irq,
    output logic             err
);

    localparam int                c_CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_TOP = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_ONE     = WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SQR      = 3'd2,
        SQR_WAIT = 3'd3,
        MUL      = 3'd4,
        MUL_WAIT = 3'd5,
        NEXT     = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_start_prev;
    logic [WIDTH-1:0]   r_base;
    logic [WIDTH-1:0]   r_exp;
    logic [WIDTH-1:0]   r_mod;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_rsa_c;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic               w_accept;
    logic               w_sqr_phase;
    logic               w_mul_phase;

    // Previous start level tracks every cycle, so edges seen while busy or
    // disabled are consumed rather than replayed later.
    assign w_accept    = (r_state == IDLE) && ena && start && !r_start_prev && !rst;
    assign w_sqr_phase = (r_state == SQR) || (r_state == SQR_WAIT);
    assign w_mul_phase = (r_state == MUL) || (r_state == MUL_WAIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next = LOAD;
            LOAD:     w_next = (r_mod == '0) ? DONE : SQR;
            SQR:      w_next = SQR_WAIT;
            SQR_WAIT: if (mm_done) w_next = r_exp[r_cnt] ? MUL : NEXT;
            MUL:      w_next = MUL_WAIT;
            MUL_WAIT: if (mm_done) w_next = NEXT;
            NEXT:     w_next = (r_cnt == '0) ? DONE : SQR;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_start_prev <= 1'b0;
            r_base       <= '0;
            r_exp        <= '0;
            r_mod        <= '0;
            r_acc        <= '0;
            r_rsa_c      <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_start_prev <= start;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_base <= plain;
                        r_exp  <= expo;
                        r_mod  <= modulus;
                    end
                end
                LOAD: begin
                    r_acc <= (r_mod == c_ONE) ? '0 : c_ONE;
                    r_cnt <= c_CNT_TOP;
                    r_err <= (r_mod == '0);
                end
                SQR_WAIT, MUL_WAIT: begin
                    if (mm_done) r_acc <= mm_p;
                end
                NEXT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - c_CNT_ONE;
                end
                DONE: begin
                    r_rsa_c <= r_err ? '0 : r_acc;
                end
                default: ;
            endcase
        end
    end

    // Operands are decoded from state so they stay stable for the whole wait.
    assign mm_start = (r_state == SQR) || (r_state == MUL);
    assign mm_a     = (w_sqr_phase || w_mul_phase) ? r_acc : '0;
    assign mm_b     = w_sqr_phase ? r_acc : (w_mul_phase ? r_base : '0);
    assign mm_n     = (w_sqr_phase || w_mul_phase) ? r_mod : '0;
    assign rsa_c    = r_rsa_c;
    assign err      = r_err;
    assign busy     = (r_state != IDLE) || w_accept;
    assign irq      = (r_state == DONE) && irq_en;

endmodule
`default_nettype wire
